// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framer: FSM encoding and frame constants.
// Defining UART_RX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

  localparam int DEFAULT_CLK_DIV = 106;
  localparam int DATA_BITS       = 8;
  localparam int BIT_CNT_W       = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;
`endif

  // Even parity: the XOR of the data and the parity bit must be zero.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-byte FIFO with extra-MSB pointers; a push into a full FIFO is dropped
// and latches the sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  logic        overrun_r;
  logic        full_s;
  logic        pop_s;

  assign full_s   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign rx_valid = (wptr_r != rptr_r);
  assign pop_s    = rx_valid && rx_ready;
  assign rx_data  = mem_r[rptr_r[AW-1:0]];
  assign overrun  = overrun_r;

  // Storage, pointers and overrun flag; full wins over a same-cycle pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_r    <= '0;
      rptr_r    <= '0;
      overrun_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      if (push && !full_s) begin
        mem_r[wptr_r[AW-1:0]] <= push_data;
        wptr_r                <= wptr_r + {{AW{1'b0}}, 1'b1};
      end else if (push) begin
        overrun_r <= 1'b1;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a byte FIFO.
// Optional even parity when UART_RX_PARITY_EN is defined; default build is 8N1.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLK_DIV - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 line_s;
  rx_state_e            state_r;
  logic [CW-1:0]        cnt_r;
  logic [BIT_CNT_W-1:0] bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 frame_err_r;
  logic                 expiry_s;
  logic                 stop_ok_s;
  logic                 push_s;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad_r;
`endif

  assign line_s    = sync2_r;
  assign expiry_s  = (cnt_r == '0);
  assign push_s    = expiry_s && (state_r == ST_STOP) && stop_ok_s;
  assign frame_err = frame_err_r;

  // Two-flop synchronizer for the asynchronous serial input; resets to idle-high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= ser_rx;
      sync2_r <= sync1_r;
    end
  end

  // A frame is accepted only with a high stop bit (and good parity when enabled).
  always_comb begin
    stop_ok_s = line_s;
`ifdef UART_RX_PARITY_EN
    stop_ok_s = line_s && !parity_bad_r;
`else
    stop_ok_s = line_s;
`endif
  end

  // Framing FSM: half-bit delay to the start-bit centre, then full-bit steps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      bit_idx_r    <= '0;
      shift_r      <= '0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_r <= 1'b0;
`endif
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!line_s) begin
            state_r <= ST_START;
            cnt_r   <= HALF_RELOAD;
          end
        end
        ST_START: begin
          if (!expiry_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else if (line_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r   <= ST_DATA;
            cnt_r     <= FULL_RELOAD;
            bit_idx_r <= '0;
          end
        end
        ST_DATA: begin
          if (!expiry_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            shift_r   <= {line_s, shift_r[DATA_BITS-1:1]};
            cnt_r     <= FULL_RELOAD;
            bit_idx_r <= bit_idx_r + BIT_CNT_W'(1);
            if (bit_idx_r == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (!expiry_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            parity_bad_r <= even_parity(shift_r) ^ line_s;
            cnt_r        <= FULL_RELOAD;
            state_r      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (!expiry_s) begin
            cnt_r <= cnt_r - CW'(1);
          end else begin
            frame_err_r <= !stop_ok_s;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push_s),
    .push_data(shift_r),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun)
  );

endmodule
